mem_bus_arbiter: RTL and testbench

- Sequences and shares the single memory bus (address, read/write strobes, data) between two requesters: the CPU datapath's memory-access control and the debug/loader port.
- Latches one request at a time and drives active-low strobes for a fixed number of wait cycles.
- Returns read data and a one-cycle ready pulse to the owning requester.
- Uses round-robin arbitration when both requesters contend.

---
 rtl/mem_bus_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory bus between the CPU memory-access
// control and the debug/loader port. One access is latched at a time, the
// active-low strobe is held for WAIT_CYCLES cycles, then the owner receives
// its read data and a one-cycle ready pulse. Round-robin on contention.
module mem_bus_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] memAddr,
  output logic              mem_re_L,
  output logic              mem_we_L,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        grant,
  output logic              busy
);

  // A zero-length strobe cannot be sequenced, so refuse to elaborate.
  if (WAIT_CYCLES < 1) begin : g_bad_wait_cycles
    $error("mem_bus_arbiter: WAIT_CYCLES must be >= 1");
  end

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              last_owner_dbg;
  logic              cur_we;

  logic              any_req;
  logic              pick_dbg;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // Round-robin choice: a lone requester wins, on contention the one that
  // did not own the bus last time wins.
  always_comb begin
    any_req   = cpu_req | dbg_req;
    pick_dbg  = dbg_req & (~cpu_req | ~last_owner_dbg);
    sel_we    = pick_dbg ? dbg_we    : cpu_we;
    sel_addr  = pick_dbg ? dbg_addr  : cpu_addr;
    sel_wdata = pick_dbg ? dbg_wdata : cpu_wdata;
  end

  // Transaction sequencer; every bus and handshake output is a register here.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      count          <= '0;
      last_owner_dbg <= 1'b1;
      cur_we         <= 1'b0;
      memAddr        <= '0;
      mem_wdata      <= '0;
      mem_re_L       <= 1'b1;
      mem_we_L       <= 1'b1;
      cpu_ready      <= 1'b0;
      dbg_ready      <= 1'b0;
      cpu_rdata      <= '0;
      dbg_rdata      <= '0;
      grant          <= 2'b00;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            memAddr   <= sel_addr;
            mem_wdata <= sel_wdata;
            cur_we    <= sel_we;
            grant     <= pick_dbg ? 2'b10 : 2'b01;
            mem_re_L  <= sel_we;
            mem_we_L  <= ~sel_we;
            count     <= CNT_LOAD;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (count == '0) begin
            mem_re_L <= 1'b1;
            mem_we_L <= 1'b1;
            if (!cur_we) begin
              if (grant[1]) begin
                dbg_rdata <= mem_rdata;
              end else begin
                cpu_rdata <= mem_rdata;
              end
            end
            cpu_ready      <= grant[0];
            dbg_ready      <= grant[1];
            last_owner_dbg <= grant[1];
            state          <= DONE;
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        DONE: begin
          cpu_ready <= 1'b0;
          dbg_ready <= 1'b0;
          grant     <= 2'b00;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by randomized
// request patterns, all compared against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int W = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpuReq = 1'b0, cpuWe = 1'b0;
  logic [15:0] cpuAddr = '0, cpuWdata = '0;
  logic        dbgReq = 1'b0, dbgWe = 1'b0;
  logic [15:0] dbgAddr = '0, dbgWdata = '0;
  logic [15:0] memRdata = '0;
  logic        cpuReady, dbgReady, memReL, memWeL, busy;
  logic [15:0] cpuRdata, dbgRdata, memAddr, memWdata;
  logic [1:0]  grant;

  // Shared stimulus for the WAIT_CYCLES sweep instances
  logic        swReq = 1'b0;
  logic [15:0] swRdata = 16'hBEEF;
  logic        s1CpuReady, s1DbgReady, s1ReL, s1WeL, s1Busy;
  logic [15:0] s1CpuRdata, s1DbgRdata, s1Addr, s1Wdata;
  logic [1:0]  s1Grant;
  logic        s5CpuReady, s5DbgReady, s5ReL, s5WeL, s5Busy;
  logic [15:0] s5CpuRdata, s5DbgRdata, s5Addr, s5Wdata;
  logic [1:0]  s5Grant;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state: who owned the bus last and the held read data
  bit          lastDbg = 1'b1;
  logic [15:0] expCpuRdata = '0;
  logic [15:0] expDbgRdata = '0;

  always #5 clock = ~clock;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_wdata(cpuWdata),
    .cpu_ready(cpuReady), .cpu_rdata(cpuRdata),
    .dbg_req(dbgReq), .dbg_we(dbgWe), .dbg_addr(dbgAddr), .dbg_wdata(dbgWdata),
    .dbg_ready(dbgReady), .dbg_rdata(dbgRdata),
    .memAddr(memAddr), .mem_re_L(memReL), .mem_we_L(memWeL),
    .mem_wdata(memWdata), .mem_rdata(memRdata), .grant(grant), .busy(busy)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dutW1 (
    .clock(clock), .reset(reset),
    .cpu_req(swReq), .cpu_we(1'b0), .cpu_addr(16'h0040), .cpu_wdata(16'h0000),
    .cpu_ready(s1CpuReady), .cpu_rdata(s1CpuRdata),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
    .dbg_ready(s1DbgReady), .dbg_rdata(s1DbgRdata),
    .memAddr(s1Addr), .mem_re_L(s1ReL), .mem_we_L(s1WeL),
    .mem_wdata(s1Wdata), .mem_rdata(swRdata), .grant(s1Grant), .busy(s1Busy)
  );

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(5)) dutW5 (
    .clock(clock), .reset(reset),
    .cpu_req(swReq), .cpu_we(1'b0), .cpu_addr(16'h0040), .cpu_wdata(16'h0000),
    .cpu_ready(s5CpuReady), .cpu_rdata(s5CpuRdata),
    .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
    .dbg_ready(s5DbgReady), .dbg_rdata(s5DbgRdata),
    .memAddr(s5Addr), .mem_re_L(s5ReL), .mem_we_L(s5WeL),
    .mem_wdata(s5Wdata), .mem_rdata(swRdata), .grant(s5Grant), .busy(s5Busy)
  );

  // One comparison: counts it, and on mismatch counts and reports the failure
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive both requesters' inputs (called at a falling edge)
  task automatic applyStimulus(input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                               input bit dr, input bit dw, input logic [15:0] da, input logic [15:0] dd);
    cpuReq = cr; cpuWe = cw; cpuAddr = ca; cpuWdata = cd;
    dbgReq = dr; dbgWe = dw; dbgAddr = da; dbgWdata = dd;
  endtask

  // Every output must sit at its reset value
  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".memAddr"}, memAddr, 0);
    checkOutput({tag, ".memWdata"}, memWdata, 0);
    checkOutput({tag, ".strobes"}, {memReL, memWeL}, 2'b11);
    checkOutput({tag, ".ready"}, {cpuReady, dbgReady}, 2'b00);
    checkOutput({tag, ".rdata"}, {cpuRdata, dbgRdata}, 32'h0);
    checkOutput({tag, ".grantBusy"}, {grant, busy}, 3'b000);
  endtask

  task automatic modelReset();
    lastDbg = 1'b1;
    expCpuRdata = '0;
    expDbgRdata = '0;
  endtask

  // One clock; the arbiter must be idle with quiet strobes afterwards
  task automatic checkIdle(input string tag);
    @(posedge clock);
    @(negedge clock);
    checkOutput({tag, ".idleGrantBusy"}, {grant, busy}, 3'b000);
    checkOutput({tag, ".idleStrobes"}, {memReL, memWeL}, 2'b11);
    checkOutput({tag, ".idleReady"}, {cpuReady, dbgReady}, 2'b00);
  endtask

  // Runs one whole access from the current (idle) state, scrambling requester
  // operands and memory data while the access is in flight
  task automatic runTransaction(input string tag, input logic [15:0] finalRdata);
    bit          ownerDbg;
    bit          we;
    logic [15:0] addr, wdata, captured;
    logic [1:0]  expGrant;
    ownerDbg = (cpuReq && dbgReq) ? !lastDbg : dbgReq;
    we       = ownerDbg ? dbgWe : cpuWe;
    addr     = ownerDbg ? dbgAddr : cpuAddr;
    wdata    = ownerDbg ? dbgWdata : cpuWdata;
    expGrant = ownerDbg ? 2'b10 : 2'b01;
    captured = '0;
    @(posedge clock);
    @(negedge clock);
    for (int i = 1; i <= W; i++) begin
      checkOutput({tag, ".grant"}, grant, expGrant);
      checkOutput({tag, ".busy"}, busy, 1);
      checkOutput({tag, ".memAddr"}, memAddr, addr);
      checkOutput({tag, ".memWdata"}, memWdata, wdata);
      checkOutput({tag, ".strobes"}, {memReL, memWeL}, we ? 2'b10 : 2'b01);
      checkOutput({tag, ".readyEarly"}, {cpuReady, dbgReady}, 2'b00);
      cpuAddr  = 16'h0099 ^ 16'($urandom);
      cpuWdata = 16'($urandom);
      cpuWe    = 1'($urandom);
      dbgAddr  = 16'($urandom);
      dbgWdata = 16'($urandom);
      dbgWe    = 1'($urandom);
      captured = (i == W) ? finalRdata : 16'($urandom);
      memRdata = captured;
      @(posedge clock);
      @(negedge clock);
    end
    if (!we) begin
      if (ownerDbg) expDbgRdata = captured;
      else          expCpuRdata = captured;
    end
    lastDbg = ownerDbg;
    checkOutput({tag, ".ready"}, {cpuReady, dbgReady}, ownerDbg ? 2'b01 : 2'b10);
    checkOutput({tag, ".doneStrobes"}, {memReL, memWeL}, 2'b11);
    checkOutput({tag, ".doneGrant"}, grant, expGrant);
    checkOutput({tag, ".doneBusy"}, busy, 1);
    checkOutput({tag, ".cpuRdata"}, cpuRdata, expCpuRdata);
    checkOutput({tag, ".dbgRdata"}, dbgRdata, expDbgRdata);
  endtask

  initial begin
    bit          inDone;
    bit          cr, dr;
    int          s1Low, s5Low, s1ReadyAt, s5ReadyAt, s1IdleAt, s5IdleAt, s1Pulses, s5Pulses;

    // Power-on reset
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkResetValues("reset");
    @(negedge clock);
    reset = 1'b0;
    modelReset();

    // CPU read of 0x0040 returning 0xBEEF
    applyStimulus(1, 0, 16'h0040, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    runTransaction("cpuRead", 16'hBEEF);
    checkOutput("cpuRead.value", cpuRdata, 16'hBEEF);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    checkIdle("cpuRead");

    // Debug write of 0x00FF to 0x1234
    applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h1234, 16'h00FF);
    runTransaction("dbgWrite", 16'h5A5A);
    checkOutput("dbgWrite.cpuRdataHeld", cpuRdata, 16'hBEEF);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    checkIdle("dbgWrite");

    // Contention straight after reset: CPU, then debug, then CPU again
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    applyStimulus(1, 0, 16'h0040, 16'h0001, 1, 0, 16'h0200, 16'h0002);
    runTransaction("rr1", 16'h1111);
    checkOutput("rr1.cpuFirst", lastDbg, 0);
    applyStimulus(1, 0, 16'h0041, 16'h0003, 1, 0, 16'h0200, 16'h0002);
    checkIdle("rr1");
    runTransaction("rr2", 16'h2222);
    checkOutput("rr2.dbgSecond", lastDbg, 1);
    applyStimulus(1, 0, 16'h0041, 16'h0003, 1, 0, 16'h0201, 16'h0004);
    checkIdle("rr2");
    runTransaction("rr3", 16'h3333);
    checkOutput("rr3.cpuThird", lastDbg, 0);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    checkIdle("rr3");

    // Reset pulse in the middle of a debug read
    applyStimulus(0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0300, 16'h0000);
    @(posedge clock);
    @(negedge clock);
    checkOutput("midReset.strobeLow", memReL, 0);
    #2 reset = 1'b1;
    #1;
    checkResetValues("midReset");
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    for (int k = 0; k < W + 3; k++) begin
      @(negedge clock);
      checkOutput("midReset.noReady", {cpuReady, dbgReady, busy}, 3'b000);
    end
    applyStimulus(1, 0, 16'h0777, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    runTransaction("afterReset", 16'hC0DE);
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    checkIdle("afterReset");

    // Randomized request patterns, back to back where requests persist
    inDone = 1'b0;
    for (int it = 0; it < 40; it++) begin
      cr = 1'($urandom);
      dr = 1'($urandom);
      applyStimulus(cr, 1'($urandom), 16'($urandom), 16'($urandom),
                    dr, 1'($urandom), 16'($urandom), 16'($urandom));
      if (inDone) checkIdle("rand");
      inDone = 1'b0;
      if (cr || dr) begin
        runTransaction("rand", 16'($urandom));
        inDone = 1'b1;
      end else begin
        checkIdle("randNoReq");
      end
    end
    applyStimulus(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    checkIdle("randEnd");

    // WAIT_CYCLES sweep: request held for one edge only, then dropped
    s1Low = 0; s5Low = 0; s1ReadyAt = 0; s5ReadyAt = 0;
    s1IdleAt = 0; s5IdleAt = 0; s1Pulses = 0; s5Pulses = 0;
    swReq = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      if (k == 1) swReq = 1'b0;
      if (!s1ReL) s1Low++;
      if (!s5ReL) s5Low++;
      if (s1CpuReady) begin s1Pulses++; if (s1ReadyAt == 0) s1ReadyAt = k; end
      if (s5CpuReady) begin s5Pulses++; if (s5ReadyAt == 0) s5ReadyAt = k; end
      if (!s1Busy && s1IdleAt == 0) s1IdleAt = k;
      if (!s5Busy && s5IdleAt == 0) s5IdleAt = k;
    end
    checkOutput("w1.strobeWidth", s1Low, 1);
    checkOutput("w5.strobeWidth", s5Low, 5);
    checkOutput("w1.readyCycle", s1ReadyAt, 2);
    checkOutput("w5.readyCycle", s5ReadyAt, 6);
    checkOutput("w1.length", s1IdleAt, 3);
    checkOutput("w5.length", s5IdleAt, 7);
    checkOutput("w1.pulses", s1Pulses, 1);
    checkOutput("w5.pulses", s5Pulses, 1);
    checkOutput("w1.rdata", s1CpuRdata, 16'hBEEF);
    checkOutput("w5.rdata", s5CpuRdata, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
